// File: rtl/npu_seq_pkg.sv
// rtl/npu_seq_pkg.sv - state encoding and signature constants shared by npu_selftest_seq
package npu_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EN_PULSE,
        S_CFG,
        S_CFG_GAP,
        S_PUSH,
        S_SETTLE,
        S_DRAIN_WAIT,
        S_DRAIN_RD,
        S_DRAIN_CAP,
        S_FIN
    } seq_state_t;

    localparam logic [15:0] MISR_POLY    = 16'h1021;
    localparam logic [15:0] MISR_SEED    = 16'hFFFF;
    localparam logic [15:0] SSFR_DEFAULT = 16'h2280;

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
    endfunction

endpackage

// File: rtl/npu_sig_misr.sv
// rtl/npu_sig_misr.sv - read-data signature register; NPU_SIG_MISR_EN selects MISR vs last-value capture
module npu_sig_misr #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          capture,
    input  logic [DW-1:0] din,
    output logic [15:0]   sig
);
    import npu_seq_pkg::*;

    logic [15:0] din16;
    logic [15:0] seed;
    logic [15:0] sig_next;

    generate
        if (DW >= 16) begin : g_trunc
            assign din16 = din[15:0];
        end else begin : g_ext
            assign din16 = {{(16-DW){1'b0}}, din};
        end
    endgenerate

`ifdef NPU_SIG_MISR_EN
    assign seed     = MISR_SEED;
    assign sig_next = misr_step(sig, din16);
`else
    assign seed     = 16'h0000;
    assign sig_next = din16;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (capture) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/npu_selftest_seq.sv
// rtl/npu_selftest_seq.sv - on-chip bring-up sequencer for npu_top (signature mode via NPU_SIG_MISR_EN)
module npu_selftest_seq
    import npu_seq_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DW         = 8,
    parameter int VEC_DEPTH  = 16,
    parameter int SETTLE_CYC = 16,
    parameter int MAX_WAIT   = 1000,
    parameter int CW         = 8
) (
    input  logic                           CLKEXT,
    input  logic                           RST_GLO_N,
    input  logic                           START,
    input  logic                           ABORT,
    input  logic                           CFG_EN,
    input  logic [15:0]                    SSFR_CFG,
    input  logic [$clog2(VEC_DEPTH+1)-1:0] NUM_VEC,
    input  logic [CW-1:0]                  NUM_RD,
    input  logic                           VLD_WE,
    input  logic [$clog2(VEC_DEPTH)-1:0]   VLD_ADDR,
    input  logic [LANES*DW-1:0]            VLD_DATA,
    output logic                           EN_FSM,
    output logic                           EN_CONFIG,
    output logic [LANES*DW-1:0]            D_LANES,
    output logic                           RD_EN,
    input  logic [DW-1:0]                  D_OUT,
    input  logic                           EMPTY,
    input  logic                           FULL,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           TIMEOUT,
    output logic                           OVF_SEEN,
    output logic [CW-1:0]                  RD_DONE_CNT,
    output logic [15:0]                    SIGNATURE
);
    localparam int VW = $clog2(VEC_DEPTH+1);
    localparam int AW = $clog2(VEC_DEPTH);
    localparam int SW = $clog2(SETTLE_CYC+1);
    localparam int GW = $clog2(MAX_WAIT+1);

    seq_state_t state, state_nxt, after_cfg;

    logic [LANES*DW-1:0] vec_mem [VEC_DEPTH];

    logic          cfg_en_q;
    logic [15:0]   ssfr_q;
    logic [VW-1:0] num_vec_q;
    logic [VW-1:0] vec_idx;
    logic [CW-1:0] num_rd_q;
    logic [CW-1:0] rd_cnt;
    logic [SW-1:0] settle_cnt;
    logic [GW-1:0] guard;
    logic          done_q;
    logic          timeout_q;
    logic          ovf_q;
    logic          start_acc;
    logic          capture;

    assign start_acc = (state == S_IDLE) && START && !ABORT;
    assign capture   = (state == S_DRAIN_CAP) && !ABORT;
    assign after_cfg = (num_vec_q != '0) ? S_PUSH : S_SETTLE;

    // Memory has no reset so stored vectors survive a global reset.
    always_ff @(posedge CLKEXT) begin
        if (VLD_WE && state == S_IDLE) begin
            vec_mem[VLD_ADDR] <= VLD_DATA;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:       if (START) state_nxt = S_EN_PULSE;
            S_EN_PULSE:   state_nxt = cfg_en_q ? S_CFG : after_cfg;
            S_CFG:        state_nxt = S_CFG_GAP;
            S_CFG_GAP:    state_nxt = after_cfg;
            S_PUSH:       if (vec_idx == num_vec_q - VW'(1)) state_nxt = S_SETTLE;
            S_SETTLE:     if (settle_cnt == SW'(SETTLE_CYC-1))
                              state_nxt = (num_rd_q == '0) ? S_FIN : S_DRAIN_WAIT;
            S_DRAIN_WAIT: if (!EMPTY) state_nxt = S_DRAIN_RD;
                          else if (guard == GW'(MAX_WAIT-1)) state_nxt = S_FIN;
            S_DRAIN_RD:   state_nxt = S_DRAIN_CAP;
            S_DRAIN_CAP:  state_nxt = ((rd_cnt + CW'(1)) == num_rd_q) ? S_FIN : S_DRAIN_WAIT;
            S_FIN:        state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
        if (ABORT) state_nxt = S_IDLE;
    end

    always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
        if (!RST_GLO_N) begin
            state      <= S_IDLE;
            cfg_en_q   <= 1'b0;
            ssfr_q     <= SSFR_DEFAULT;
            num_vec_q  <= '0;
            num_rd_q   <= '0;
            vec_idx    <= '0;
            rd_cnt     <= '0;
            settle_cnt <= '0;
            guard      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            vec_idx    <= (state == S_PUSH) ? vec_idx + VW'(1) : '0;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + SW'(1) : '0;
            guard      <= (state == S_DRAIN_WAIT && EMPTY) ? guard + GW'(1) : '0;
            if (start_acc) begin
                cfg_en_q  <= CFG_EN;
                ssfr_q    <= SSFR_CFG;
                num_vec_q <= (NUM_VEC > VW'(VEC_DEPTH)) ? VW'(VEC_DEPTH) : NUM_VEC;
                num_rd_q  <= NUM_RD;
                rd_cnt    <= '0;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                ovf_q     <= 1'b0;
            end
            if (capture) rd_cnt <= rd_cnt + CW'(1);
            if (state_nxt == S_FIN) done_q <= 1'b1;
            if (state == S_DRAIN_WAIT && state_nxt == S_FIN) timeout_q <= 1'b1;
            if (BUSY && FULL) ovf_q <= 1'b1;
        end
    end

    // Pulses and lanes are decoded from state and forced quiet in an ABORT cycle.
    always_comb begin
        EN_FSM    = 1'b0;
        EN_CONFIG = 1'b0;
        RD_EN     = 1'b0;
        D_LANES   = '0;
        if (!ABORT) begin
            unique case (state)
                S_EN_PULSE: EN_FSM = 1'b1;
                S_CFG: begin
                    EN_CONFIG           = 1'b1;
                    D_LANES[DW-1:0]     = DW'(ssfr_q[15:8]);
                    D_LANES[2*DW-1:DW]  = DW'(ssfr_q[7:0]);
                end
                S_PUSH:     D_LANES = vec_mem[vec_idx[AW-1:0]];
                S_DRAIN_RD: RD_EN = 1'b1;
                default: ;
            endcase
        end
    end

    assign BUSY        = (state != S_IDLE) && (state != S_FIN);
    assign DONE        = done_q;
    assign TIMEOUT     = timeout_q;
    assign OVF_SEEN    = ovf_q;
    assign RD_DONE_CNT = rd_cnt;

    npu_sig_misr #(.DW(DW)) u_sig (
        .clk     (CLKEXT),
        .rst_n   (RST_GLO_N),
        .load    (start_acc),
        .capture (capture),
        .din     (D_OUT),
        .sig     (SIGNATURE)
    );

endmodule
